// File: rtl/calc_exec_unit.sv
// Execute core for the keypad calculator: register file, operand read sequencer, ALU and writeback.
// Optional SATURATE_EN macro clamps overflowing ADD/SUB/MUL results to the signed limit.
module calc_exec_unit #(
    parameter int  DATA_W   = 9,
    parameter int  NUM_REGS = 8,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [REG_AW-1:0] src_a,
    input  logic [REG_AW-1:0] src_b,
    input  logic [REG_AW-1:0] dst,
    input  logic [REG_AW-1:0] rd_reg,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              wr_err
);

    localparam int SH_W     = $clog2(DATA_W);
    localparam int PAD_REGS = 2 ** REG_AW;
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

    state_t              state_reg;
    logic [2:0]          opcode_reg;
    logic [REG_AW-1:0]   src_a_reg, src_b_reg, dst_reg;
    logic [DATA_W-1:0]   op_a_reg, op_b_reg, res_reg, result_reg;
    logic                ovf_reg, overflow_reg, busy_reg, done_reg;
    logic [DATA_W-1:0]   res_next;
    logic                ovf_next;

    // Index space padded to a power of two; slots beyond NUM_REGS read as zero and never store.
    logic [PAD_REGS-1:0][DATA_W-1:0] regs_pad;

    genvar gi;
    generate
        for (gi = 0; gi < PAD_REGS; gi++) begin : g_regs
            if (gi < NUM_REGS) begin : g_live
                logic [DATA_W-1:0] q_reg;
                always_ff @(posedge hwclk) begin
                    if (reset)
                        q_reg <= '0;
                    else if (state_reg == WB && dst_reg == REG_AW'(gi))
                        q_reg <= res_reg;
                    else if (wr_en && state_reg == IDLE && wr_reg == REG_AW'(gi))
                        q_reg <= wr_data;
                end
                assign regs_pad[gi] = q_reg;
            end else begin : g_pad
                assign regs_pad[gi] = '0;
            end
        end
    endgenerate

    logic [DATA_W:0]          sum_ext, dif_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic [SH_W-1:0]          shamt;

    assign sum_ext = {op_a_reg[DATA_W-1], op_a_reg} + {op_b_reg[DATA_W-1], op_b_reg};
    assign dif_ext = {op_a_reg[DATA_W-1], op_a_reg} - {op_b_reg[DATA_W-1], op_b_reg};
    assign prod    = (2*DATA_W)'($signed(op_a_reg)) * (2*DATA_W)'($signed(op_b_reg));
    assign shamt   = op_b_reg[SH_W-1:0];

    // The extra top bit of sum/dif and the top bit of prod carry the true sign for saturation.
    always_comb begin
        res_next = op_a_reg;
        ovf_next = 1'b0;
        case (opcode_reg)
            3'b000: begin
                res_next = sum_ext[DATA_W-1:0];
                ovf_next = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
                if (SAT && ovf_next) res_next = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
            end
            3'b001: begin
                res_next = dif_ext[DATA_W-1:0];
                ovf_next = dif_ext[DATA_W] ^ dif_ext[DATA_W-1];
                if (SAT && ovf_next) res_next = dif_ext[DATA_W] ? SAT_MIN : SAT_MAX;
            end
            3'b010: begin
                res_next = prod[DATA_W-1:0];
                ovf_next = prod[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod[DATA_W-1]}};
                if (SAT && ovf_next) res_next = prod[2*DATA_W-1] ? SAT_MIN : SAT_MAX;
            end
            3'b011: res_next = op_a_reg & op_b_reg;
            3'b100: res_next = op_a_reg | op_b_reg;
            3'b101: res_next = op_a_reg ^ op_b_reg;
            3'b110: res_next = (32'(shamt) >= DATA_W) ? '0 : (op_a_reg << shamt);
            default: res_next = op_a_reg;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_reg    <= IDLE;
            opcode_reg   <= '0;
            src_a_reg    <= '0;
            src_b_reg    <= '0;
            dst_reg      <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            res_reg      <= '0;
            ovf_reg      <= 1'b0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    opcode_reg <= opcode;
                    src_a_reg  <= src_a;
                    src_b_reg  <= src_b;
                    dst_reg    <= dst;
                    busy_reg   <= 1'b1;
                    state_reg  <= RD_A;
                end
                RD_A: begin
                    op_a_reg  <= regs_pad[src_a_reg];
                    state_reg <= RD_B;
                end
                RD_B: begin
                    op_b_reg  <= regs_pad[src_b_reg];
                    state_reg <= EXEC;
                end
                EXEC: begin
                    res_reg   <= res_next;
                    ovf_reg   <= ovf_next;
                    done_reg  <= 1'b1;
                    state_reg <= WB;
                end
                WB: begin
                    result_reg   <= res_reg;
                    overflow_reg <= ovf_reg;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rd_data  = regs_pad[rd_reg];
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign overflow = overflow_reg;
    assign wr_err   = wr_en & busy_reg;

endmodule

// File: tb/tb_calc_exec_unit.sv
// Directed self-checking bench for calc_exec_unit (DATA_W=9, NUM_REGS=8).
module tb_calc_exec_unit;

    logic       hwclk = 1'b0;
    logic       reset, wr_en, start;
    logic [2:0] wr_reg, src_a, src_b, dst, rd_reg, opcode;
    logic [8:0] wr_data, rd_data, result;
    logic       busy, done, overflow, wr_err;

    int n_checks = 0;
    int n_fails  = 0;

    calc_exec_unit #(.DATA_W(9), .NUM_REGS(8)) dut (
        .hwclk(hwclk), .reset(reset), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .start(start), .opcode(opcode), .src_a(src_a), .src_b(src_b), .dst(dst),
        .rd_reg(rd_reg), .rd_data(rd_data), .busy(busy), .done(done),
        .result(result), .overflow(overflow), .wr_err(wr_err)
    );

    always #5 hwclk = ~hwclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] r, input logic [8:0] d);
        wr_en = 1'b1; wr_reg = r; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] r, input logic [8:0] exp);
        rd_reg = r;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d);
        opcode = op; src_a = a; src_b = b; dst = d; start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    // Called in the RD_A cycle; done is expected in the fourth cycle after the start cycle.
    task automatic finish_op(input string tag, input logic [2:0] d,
                             input logic [8:0] er, input logic eo);
        int lat;
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        tick();
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " busy clear"}, 32'(busy), 32'd0);
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " overflow"}, 32'(overflow), 32'(eo));
        read_chk({tag, " dst reg"}, d, er);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] d,
                          input logic [8:0] er, input logic eo);
        issue(op, a, b, d);
        finish_op(tag, d, er, eo);
    endtask

    int done_cnt;

    initial begin
        reset = 1'b1; wr_en = 1'b0; start = 1'b0;
        wr_reg = '0; wr_data = '0; src_a = '0; src_b = '0; dst = '0; rd_reg = '0; opcode = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) read_chk($sformatf("reset r%0d", i), 3'(i), 9'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset wr_err", 32'(wr_err), 32'd0);

        write_reg(3'd1, 9'd100);
        write_reg(3'd2, 9'd55);
        run_op("add 100+55", 3'b000, 3'd1, 3'd2, 3'd3, 9'd155, 1'b0);

        write_reg(3'd1, 9'd200);
        write_reg(3'd2, 9'd100);
`ifdef SATURATE_EN
        run_op("add 200+100", 3'b000, 3'd1, 3'd2, 3'd3, 9'h0FF, 1'b1);
`else
        run_op("add 200+100", 3'b000, 3'd1, 3'd2, 3'd3, 9'h12C, 1'b1);
`endif

        write_reg(3'd1, 9'h1EC);
        write_reg(3'd2, 9'd13);
`ifdef SATURATE_EN
        run_op("mul -20*13", 3'b010, 3'd1, 3'd2, 3'd1, 9'h100, 1'b1);
`else
        run_op("mul -20*13", 3'b010, 3'd1, 3'd2, 3'd1, 9'h0FC, 1'b1);
`endif
        run_op("sub r1-r1", 3'b001, 3'd1, 3'd1, 3'd2, 9'd0, 1'b0);

        write_reg(3'd4, 9'h0F0);
        write_reg(3'd5, 9'h03C);
        write_reg(3'd6, 9'd3);
        write_reg(3'd7, 9'd9);
        run_op("and", 3'b011, 3'd4, 3'd5, 3'd3, 9'h030, 1'b0);
        run_op("or", 3'b100, 3'd4, 3'd5, 3'd3, 9'h0FC, 1'b0);
        run_op("xor", 3'b101, 3'd4, 3'd5, 3'd3, 9'h0CC, 1'b0);
        run_op("shl by 3", 3'b110, 3'd5, 3'd6, 3'd3, 9'h1E0, 1'b0);
        run_op("shl by 9", 3'b110, 3'd5, 3'd7, 3'd3, 9'h000, 1'b0);

        // Write and second start while busy must both be dropped.
        issue(3'b100, 3'd4, 3'd5, 3'd6);
        wr_en = 1'b1; wr_reg = 3'd5; wr_data = 9'd7;
        opcode = 3'b111; src_a = 3'd1; dst = 3'd2; start = 1'b1;
        #1;
        check("busy wr_err high", 32'(wr_err), 32'd1);
        check("busy flag", 32'(busy), 32'd1);
        tick();
        wr_en = 1'b0; start = 1'b0;
        #1;
        check("wr_err one cycle", 32'(wr_err), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("single done", 32'(done_cnt), 32'd1);
        read_chk("r5 unchanged", 3'd5, 9'h03C);
        read_chk("r6 or result", 3'd6, 9'h0FC);
        read_chk("r2 untouched", 3'd2, 9'd0);

        // Abort during EXEC.
        issue(3'b111, 3'd5, 3'd5, 3'd4);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("abort no done", 32'(done_cnt), 32'd0);
        read_chk("abort r4", 3'd4, 9'd0);

        // Same-cycle write and start: RD_A sees the new value.
        wr_en = 1'b1; wr_reg = 3'd1; wr_data = 9'd9;
        issue(3'b111, 3'd1, 3'd0, 3'd4);
        finish_op("pass after write", 3'd4, 9'd9, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
